// File: rtl/ripple_carry_adder_8bit_pkg.sv
// Shared constants for the ripple-carry adder leaf block.
//   RCA_DEFAULT_WIDTH : default operand/sum width in bits.
package ripple_carry_adder_8bit_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 8;

endpackage : ripple_carry_adder_8bit_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple chain in the top instantiates one per bit.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/ripple_carry_adder_8bit.sv
// WIDTH-bit ripple-carry adder with carry-in and a registered result stage.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : in1/in2/c_in are valid this cycle
//   in1, in2   : operands
//   c_in       : carry into bit 0
//   out_valid  : sum/c_out/overflow hold a result accepted on the previous edge
//   sum        : registered (in1 + in2 + c_in) mod 2^WIDTH
//   c_out      : registered carry out of the MSB
//   overflow   : registered signed overflow (carry into MSB xor carry out of MSB)
module ripple_carry_adder_8bit
  import ripple_carry_adder_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] leaves the MSB.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;

  assign w_carry[0] = c_in;

  // Carry chain: each cell consumes the previous cell's carry, no lookahead.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
    full_adder u_fa (
      .a   (in1[i]),
      .b   (in2[i]),
      .cin (w_carry[i]),
      .s   (w_sum[i]),
      .cout(w_carry[i+1])
    );
  end

  assign w_overflow = w_carry[WIDTH-1] ^ w_carry[WIDTH];

  // Result register: loads only on accepted operands so idle-cycle inputs
  // (including X) never disturb the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum      <= w_sum;
        r_c_out    <= w_carry[WIDTH];
        r_overflow <= w_overflow;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign overflow  = r_overflow;

endmodule : ripple_carry_adder_8bit

// File: tb/tb_ripple_carry_adder_8bit.sv
// Directed-vector bench for ripple_carry_adder_8bit (WIDTH = 8).
module tb_ripple_carry_adder_8bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       c_in;
  logic       out_valid;
  logic [7:0] sum;
  logic       c_out;
  logic       overflow;

  int n_tests;
  int n_failed;

  ripple_carry_adder_8bit #(.WIDTH(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in1      (in1),
    .in2      (in2),
    .c_in     (c_in),
    .out_valid(out_valid),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check the full output bundle against hand-computed values.
  task automatic check_out(input string tag, input logic ev, input logic [7:0] es,
                           input logic ec, input logic eo);
    check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".sum"},   32'(sum),       32'(es));
    check({tag, ".cout"},  32'(c_out),     32'(ec));
    check({tag, ".ovf"},   32'(overflow),  32'(eo));
  endtask

  // Present one operand set for a single edge, then sample 1ns after it.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic ci);
    in1      = a;
    in2      = b;
    c_in     = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in1      = 'x;
    in2      = 'x;
    c_in     = 1'bx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;
    c_in     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 8'd0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single vectors, each followed by an idle cycle.
    apply(8'd102, 8'd103, 1'b0); check_out("v102_103", 1'b1, 8'd205, 1'b0, 1'b1);
    idle_cycle();                check_out("idle_hold", 1'b0, 8'd205, 1'b0, 1'b1);
    apply(8'd203, 8'd2,   1'b1); check_out("v203_2_1", 1'b1, 8'd206, 1'b0, 1'b0);
    apply(8'd141, 8'd114, 1'b0); check_out("v141_114", 1'b1, 8'd255, 1'b0, 1'b0);
    apply(8'd140, 8'd116, 1'b0); check_out("v140_116", 1'b1, 8'd0,   1'b1, 1'b0);
    apply(8'd139, 8'd117, 1'b1); check_out("v139_117", 1'b1, 8'd1,   1'b1, 1'b0);
    apply(8'd255, 8'd255, 1'b1); check_out("max_max1", 1'b1, 8'd255, 1'b1, 1'b0);
    apply(8'd255, 8'd0,   1'b1); check_out("ones_0_1", 1'b1, 8'd0,   1'b1, 1'b0);
    apply(8'd0,   8'd0,   1'b0); check_out("zero",     1'b1, 8'd0,   1'b0, 1'b0);
    apply(8'd128, 8'd128, 1'b0); check_out("neg_ovf",  1'b1, 8'd0,   1'b1, 1'b1);
    apply(8'd127, 8'd0,   1'b1); check_out("pos_ovf",  1'b1, 8'd128, 1'b0, 1'b1);
    idle_cycle();

    // Back-to-back stream of four, then idle with X inputs: results hold.
    apply(8'd10,  8'd20,  1'b0); check_out("s0", 1'b1, 8'd30,  1'b0, 1'b0);
    apply(8'd200, 8'd100, 1'b0); check_out("s1", 1'b1, 8'd44,  1'b1, 1'b0);
    apply(8'd64,  8'd64,  1'b1); check_out("s2", 1'b1, 8'd129, 1'b0, 1'b1);
    apply(8'd90,  8'd33,  1'b1); check_out("s3", 1'b1, 8'd124, 1'b0, 1'b0);
    idle_cycle();                check_out("s_idle0", 1'b0, 8'd124, 1'b0, 1'b0);
    idle_cycle();                check_out("s_idle1", 1'b0, 8'd124, 1'b0, 1'b0);

    // Async reset between edges while a result is valid.
    apply(8'd250, 8'd10, 1'b0);  check_out("pre_rst", 1'b1, 8'd4, 1'b1, 1'b0);
    in1 = 8'd1; in2 = 8'd1; c_in = 1'b0;   // in flight, must be discarded
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_out("rst_held", 1'b0, 8'd0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    idle_cycle();                check_out("post_rst_idle", 1'b0, 8'd0, 1'b0, 1'b0);
    apply(8'd77,  8'd23, 1'b1);  check_out("post_rst", 1'b1, 8'd101, 1'b0, 1'b0);
    idle_cycle();                check_out("post_rst_idle2", 1'b0, 8'd101, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule : tb_ripple_carry_adder_8bit
